pcie_rst_sequencer: RTL and testbench

Reset/power-on sequencer for the CPM PCIe subsystem. Drives the PS POR, CPM5 LPD POR and PCIe PERST# in a fixed, timed order, then waits for link-up with a timeout. It replaces ad-hoc forced reset sequencing with one controller shared by the EP and RP sides of the board, one instance per side.

---
 rtl/pcie_rst_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_pcie_rst_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rst_sequencer.sv
// ---------------------------------------------------------------------------
// pcie_rst_sequencer
//
// Purpose:
//   Power-on / reset sequencer for the CPM PCIe subsystem. After a start
//   request it holds all resets for HOLD_CYCLES. It then releases the PS POR,
//   the CPM5 LPD POR and PCIe PERST# in that order, STEP_CYCLES apart. Finally
//   it waits up to LINK_TIMEOUT cycles for link-up. One instance is used per
//   side of the board (EP and RP).
//
// Optional feature (compile-time macro):
//   SEQ_RETRY_EN - a link-up timeout re-runs the whole sequence from HOLD, up
//                  to MAX_RETRY times, before the sequencer gives up in ERR.
//                  Without the macro every timeout goes straight to ERR and
//                  retry_cnt_o reads 0.
//
// Ports:
//   sys_clk      in   sequencer clock (refclk domain)
//   sys_rst_n    in   asynchronous active-low reset
//   start_i      in   level; begins a sequence when the sequencer is idle
//   restart_i    in   level; aborts any non-idle state and restarts from HOLD
//   link_up_i    in   asynchronous link-up status from CPM (synchronized here)
//   por_n_o      out  PS POR, active low
//   cpm_por_n_o  out  CPM5 LPD POR, active low
//   perst_n_o    out  PCIe PERST#, active low
//   seq_busy_o   out  sequence in progress (HOLD .. WAIT_LINK)
//   seq_done_o   out  link is up
//   seq_err_o    out  sticky error (timeout or link loss)
//   state_o      out  current state encoding
//   retry_cnt_o  out  retries consumed
// ---------------------------------------------------------------------------
module pcie_rst_sequencer #(
    parameter int unsigned HOLD_CYCLES  = 500,
    parameter int unsigned STEP_CYCLES  = 16,
    parameter int unsigned LINK_TIMEOUT = 65535,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start_i,
    input  logic       restart_i,
    input  logic       link_up_i,
    output logic       por_n_o,
    output logic       cpm_por_n_o,
    output logic       perst_n_o,
    output logic       seq_busy_o,
    output logic       seq_done_o,
    output logic       seq_err_o,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOLD      = 3'd1,
        S_POR_REL   = 3'd2,
        S_CPM_REL   = 3'd3,
        S_WAIT_LINK = 3'd4,
        S_LINK_UP   = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    // The counter is cleared on the edge that enters a timed state. It then
    // reaches N-1 on the edge before the N-th. Leaving on cnt == N-1 makes the
    // transition land exactly N edges after entry.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LINK_TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             link_meta_q, link_sync_q;
    logic             por_n_q, cpm_por_n_q, perst_n_q;
    logic             busy_q, done_q, err_q;
    logic             por_n_d, cpm_por_n_d, perst_n_d;
    logic             busy_d, done_d, err_d;

`ifdef SEQ_RETRY_EN
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
    logic [1:0] retry_q, retry_d;
`endif

    // Two-flop synchronizer for the asynchronous link status.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            link_meta_q <= 1'b0;
            link_sync_q <= 1'b0;
        end else begin
            link_meta_q <= link_up_i;
            link_sync_q <= link_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = sat_inc(cnt_q);
`ifdef SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        // restart_i overrides every other transition except in IDLE.
        if (restart_i && (state_q != S_IDLE)) begin
            state_d = S_HOLD;
            cnt_d   = '0;
`ifdef SEQ_RETRY_EN
            retry_d = 2'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (start_i) begin
                        state_d = S_HOLD;
`ifdef SEQ_RETRY_EN
                        retry_d = 2'd0;
`endif
                    end
                end
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_POR_REL;
                        cnt_d   = '0;
                    end
                end
                S_POR_REL: begin
                    if (cnt_q == STEP_LAST) begin
                        state_d = S_CPM_REL;
                        cnt_d   = '0;
                    end
                end
                S_CPM_REL: begin
                    if (cnt_q == STEP_LAST) begin
                        state_d = S_WAIT_LINK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LINK: begin
                    // Link-up is checked first so it wins over a same-cycle timeout.
                    if (link_sync_q) begin
                        state_d = S_LINK_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_d = '0;
`ifdef SEQ_RETRY_EN
                        if (retry_q < RETRY_MAX) begin
                            state_d = S_HOLD;
                            retry_d = retry_q + 2'd1;
                        end else begin
                            state_d = S_ERR;
                        end
`else
                        state_d = S_ERR;
`endif
                    end
                end
                S_LINK_UP: begin
                    if (!link_sync_q) begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The outputs are a decode of the next state, registered alongside it.
    // ERR is only reachable after both PORs were released, so it keeps them
    // released. The decode also enforces the strict release order.
    assign por_n_d     = (state_d == S_POR_REL) || (state_d == S_CPM_REL) ||
                         (state_d == S_WAIT_LINK) || (state_d == S_LINK_UP) ||
                         (state_d == S_ERR);
    assign cpm_por_n_d = (state_d == S_CPM_REL) || (state_d == S_WAIT_LINK) ||
                         (state_d == S_LINK_UP) || (state_d == S_ERR);
    assign perst_n_d   = (state_d == S_WAIT_LINK) || (state_d == S_LINK_UP);
    assign busy_d      = (state_d == S_HOLD) || (state_d == S_POR_REL) ||
                         (state_d == S_CPM_REL) || (state_d == S_WAIT_LINK);
    assign done_d      = (state_d == S_LINK_UP);
    assign err_d       = (state_d == S_ERR);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            por_n_q     <= 1'b0;
            cpm_por_n_q <= 1'b0;
            perst_n_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            por_n_q     <= por_n_d;
            cpm_por_n_q <= cpm_por_n_d;
            perst_n_q   <= perst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef SEQ_RETRY_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            retry_q <= 2'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_cnt_o = retry_q;
`else
    // Retries are compiled out; the counter always reads zero.
    assign retry_cnt_o = 2'(MAX_RETRY) & 2'b00;
`endif

    assign por_n_o     = por_n_q;
    assign cpm_por_n_o = cpm_por_n_q;
    assign perst_n_o   = perst_n_q;
    assign seq_busy_o  = busy_q;
    assign seq_done_o  = done_q;
    assign seq_err_o   = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pcie_rst_sequencer.sv
module tb_pcie_rst_sequencer;

    localparam int H    = 8;
    localparam int S    = 4;
    localparam int TO   = 32;
    localparam int MAXR = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       link_up_i = 1'b0;
    logic       por_n_o, cpm_por_n_o, perst_n_o;
    logic       seq_busy_o, seq_done_o, seq_err_o;
    logic [2:0] state_o;
    logic [1:0] retry_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: phase (expected state_o), the edge at which the
    // current HOLD began, retries used, and the link samples delayed two edges.
    int m_phase = 0;
    int m_t0    = 0;
    int m_retry = 0;
    int cyc     = 0;
    bit lk_d1   = 1'b0;
    bit lk_d2   = 1'b0;

    pcie_rst_sequencer #(
        .HOLD_CYCLES (H),
        .STEP_CYCLES (S),
        .LINK_TIMEOUT(TO),
        .CNT_W       (16),
        .MAX_RETRY   (MAXR)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start_i    (start_i),
        .restart_i  (restart_i),
        .link_up_i  (link_up_i),
        .por_n_o    (por_n_o),
        .cpm_por_n_o(cpm_por_n_o),
        .perst_n_o  (perst_n_o),
        .seq_busy_o (seq_busy_o),
        .seq_done_o (seq_done_o),
        .seq_err_o  (seq_err_o),
        .state_o    (state_o),
        .retry_cnt_o(retry_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [10:0] obs();
        return {por_n_o, cpm_por_n_o, perst_n_o, seq_busy_o, seq_done_o,
                seq_err_o, state_o, retry_cnt_o};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic p, c, r, b, d, e;
        p = (m_phase >= 2);
        c = (m_phase >= 3);
        r = (m_phase == 4) || (m_phase == 5);
        b = (m_phase >= 1) && (m_phase <= 4);
        d = (m_phase == 5);
        e = (m_phase == 6);
        return {p, c, r, b, d, e, 3'(m_phase), 2'(m_retry)};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_retry = 0;
        lk_d1   = 1'b0;
        lk_d2   = 1'b0;
    endtask

    // Timeline model: the expected state is derived from the time elapsed since
    // the sequence (re)started, compared against the cumulative phase lengths.
    task automatic model_edge(input bit st, input bit rs, input bit ls);
        int el;
        if (rs && m_phase != 0) begin
            m_phase = 1; m_t0 = cyc; m_retry = 0;
        end else begin
            case (m_phase)
                0: if (st) begin m_phase = 1; m_t0 = cyc; m_retry = 0; end
                1, 2, 3: begin
                    el = cyc - m_t0;
                    if (el >= H + 2 * S)  m_phase = 4;
                    else if (el >= H + S) m_phase = 3;
                    else if (el >= H)     m_phase = 2;
                    else                  m_phase = 1;
                end
                4: begin
                    el = cyc - (m_t0 + H + 2 * S);
                    if (ls) m_phase = 5;
                    else if (el >= TO) begin
`ifdef SEQ_RETRY_EN
                        if (m_retry < MAXR) begin
                            m_phase = 1; m_t0 = cyc; m_retry++;
                        end else begin
                            m_phase = 6;
                        end
`else
                        m_phase = 6;
`endif
                    end
                end
                5: if (!ls) m_phase = 6;
                default: ;
            endcase
        end
    endtask

    // Advance one clock edge and step the model; returns 1 time unit after it.
    task automatic tick();
        @(posedge sys_clk);
        if (!sys_rst_n) begin
            model_reset();
        end else begin
            model_edge(start_i, restart_i, lk_d2);
            lk_d2 = lk_d1;
            lk_d1 = link_up_i;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        start_i = 1'b0; restart_i = 1'b0; link_up_i = 1'b0;
        model_reset();
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (obs() !== 11'b0) $display("FAIL reset_state got=%b exp=%b", obs(), 11'b0);
        else n_pass++;
        tick();
        n_chk++;
        if (obs() !== exp_vec()) $display("FAIL reset_idle got=%b exp=%b", obs(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_nominal();
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_chk++;
        if (state_o !== 3'd1) $display("FAIL nominal_hold got=%0d exp=1", state_o);
        else n_pass++;
        for (int rel = 1; rel <= 24; rel++) begin
            if (rel == 20) link_up_i = 1'b1;
            tick();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL nominal_model rel=%0d got=%b exp=%b", rel, obs(), exp_vec());
            else n_pass++;
            if (rel == 7 || rel == 8) begin
                n_chk++;
                if (por_n_o !== (rel == 8)) $display("FAIL nominal_por rel=%0d got=%b exp=%b", rel, por_n_o, rel == 8);
                else n_pass++;
            end
            if (rel == 11 || rel == 12) begin
                n_chk++;
                if (cpm_por_n_o !== (rel == 12)) $display("FAIL nominal_cpm rel=%0d got=%b exp=%b", rel, cpm_por_n_o, rel == 12);
                else n_pass++;
            end
            if (rel == 15 || rel == 16) begin
                n_chk++;
                if (perst_n_o !== (rel == 16)) $display("FAIL nominal_perst rel=%0d got=%b exp=%b", rel, perst_n_o, rel == 16);
                else n_pass++;
            end
            if (rel == 21 || rel == 22) begin
                n_chk++;
                if ({state_o, seq_done_o} !== ((rel == 22) ? 4'b1011 : 4'b1000))
                    $display("FAIL nominal_linkup rel=%0d got=%0d/%b", rel, state_o, seq_done_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int rel = 1; rel <= 52; rel++) begin
            tick();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL timeout_model rel=%0d got=%b exp=%b", rel, obs(), exp_vec());
            else n_pass++;
            if (rel == 47) begin
                n_chk++;
                if (state_o !== 3'd4) $display("FAIL timeout_early rel=47 got=%0d exp=4", state_o);
                else n_pass++;
            end
            if (rel == 48) begin
                n_chk++;
                if ({state_o, seq_err_o, perst_n_o, cpm_por_n_o, por_n_o} !== 7'b1101011)
                    $display("FAIL timeout_err rel=48 got=%b exp=%b",
                             {state_o, seq_err_o, perst_n_o, cpm_por_n_o, por_n_o}, 7'b1101011);
                else n_pass++;
            end
        end
    endtask

    task automatic test_link_at_timeout();
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int rel = 1; rel <= 50; rel++) begin
            if (rel == 46) link_up_i = 1'b1;
            tick();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL tie_model rel=%0d got=%b exp=%b", rel, obs(), exp_vec());
            else n_pass++;
            if (rel == 48) begin
                n_chk++;
                if (state_o !== 3'd5) $display("FAIL tie_linkwins rel=48 got=%0d exp=5", state_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_restart();
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int rel = 1; rel <= 22; rel++) begin
            restart_i = (rel == 10);
            tick();
            restart_i = 1'b0;
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL restart_model rel=%0d got=%b exp=%b", rel, obs(), exp_vec());
            else n_pass++;
            if (rel == 10) begin
                n_chk++;
                if ({state_o, por_n_o, cpm_por_n_o, perst_n_o} !== 6'b001000)
                    $display("FAIL restart_hold rel=10 got=%b exp=001000", {state_o, por_n_o, cpm_por_n_o, perst_n_o});
                else n_pass++;
            end
            if (rel == 17 || rel == 18) begin
                n_chk++;
                if (por_n_o !== (rel == 18)) $display("FAIL restart_por rel=%0d got=%b exp=%b", rel, por_n_o, rel == 18);
                else n_pass++;
            end
        end
    endtask

    task automatic test_link_loss();
        do_reset();
        link_up_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int rel = 1; rel <= 28; rel++) begin
            if (rel == 21) link_up_i = 1'b0;
            restart_i = (rel == 26);
            tick();
            restart_i = 1'b0;
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL loss_model rel=%0d got=%b exp=%b", rel, obs(), exp_vec());
            else n_pass++;
            if (rel == 17 || rel == 22) begin
                n_chk++;
                if (state_o !== 3'd5) $display("FAIL loss_up rel=%0d got=%0d exp=5", rel, state_o);
                else n_pass++;
            end
            if (rel == 23) begin
                n_chk++;
                if ({state_o, perst_n_o, seq_err_o} !== 5'b11001)
                    $display("FAIL loss_err rel=23 got=%b exp=11001", {state_o, perst_n_o, seq_err_o});
                else n_pass++;
            end
            if (rel == 26) begin
                n_chk++;
                if ({state_o, seq_err_o} !== 4'b0010)
                    $display("FAIL loss_restart rel=26 got=%b exp=0010", {state_o, seq_err_o});
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int rel = 1; rel <= 20; rel++) tick();
        n_chk++;
        if (state_o !== 3'd4) $display("FAIL areset_pre got=%0d exp=4", state_o);
        else n_pass++;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (obs() !== 11'b0) $display("FAIL areset_immediate got=%b exp=%b", obs(), 11'b0);
        else n_pass++;
        start_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (obs() !== 11'b0) $display("FAIL areset_held k=%0d got=%b exp=%b", k, obs(), 11'b0);
            else n_pass++;
        end
        start_i = 1'b0;
        #2;
        sys_rst_n = 1'b1;
        tick();
        n_chk++;
        if (obs() !== exp_vec()) $display("FAIL areset_release got=%b exp=%b", obs(), exp_vec());
        else n_pass++;
    endtask

`ifdef SEQ_RETRY_EN
    task automatic test_retry();
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int rel = 1; rel <= 150; rel++) begin
            tick();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL retry_model rel=%0d got=%b exp=%b", rel, obs(), exp_vec());
            else n_pass++;
            if (rel == 48 || rel == 96) begin
                n_chk++;
                if ({state_o, retry_cnt_o, por_n_o} !== {3'd1, (rel == 48) ? 2'd1 : 2'd2, 1'b0})
                    $display("FAIL retry_hold rel=%0d got=%0d/%0d/%b", rel, state_o, retry_cnt_o, por_n_o);
                else n_pass++;
            end
            if (rel == 144) begin
                n_chk++;
                if ({state_o, retry_cnt_o, seq_err_o} !== 6'b110101)
                    $display("FAIL retry_err rel=144 got=%b exp=110101", {state_o, retry_cnt_o, seq_err_o});
                else n_pass++;
            end
        end
    endtask
`endif

    task automatic test_random();
        int rate;
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            rate = 4 << blk;
            for (int k = 0; k < 500; k++) begin
                start_i   = ($urandom_range(0, 7) == 0);
                restart_i = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, rate - 1) == 0) link_up_i = ~link_up_i;
                tick();
                n_chk++;
                if (obs() !== exp_vec()) $display("FAIL random_model blk=%0d k=%0d got=%b exp=%b", blk, k, obs(), exp_vec());
                else n_pass++;
            end
        end
        start_i = 1'b0;
        restart_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_link_at_timeout();
        test_restart();
        test_link_loss();
        test_async_reset();
`ifdef SEQ_RETRY_EN
        test_retry();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
